// File: rtl/board_port_arbiter.sv
// Shares one board-BRAM port between the renderer (read-only) and the life simulator (read/write).
// Optional simulator starvation guard is compiled in when ARB_STARVE_GUARD_EN is defined.
module board_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int LOG_MAX_ADDR = 8,
  parameter int WORD_SIZE    = 16
) (
  input  logic                    clk_in,
  input  logic                    rstn_in,
  input  logic                    render_req_in,
  input  logic [LOG_MAX_ADDR-1:0] render_addr_in,
  output logic                    render_gnt_out,
  output logic [WORD_SIZE-1:0]    render_data_out,
  output logic                    render_valid_out,
  input  logic                    sim_req_in,
  input  logic                    sim_we_in,
  input  logic [LOG_MAX_ADDR-1:0] sim_addr_in,
  input  logic [WORD_SIZE-1:0]    sim_data_in,
  output logic                    sim_gnt_out,
  output logic [WORD_SIZE-1:0]    sim_data_out,
  output logic                    sim_valid_out,
  output logic [LOG_MAX_ADDR-1:0] mem_addr_out,
  output logic                    mem_we_out,
  output logic [WORD_SIZE-1:0]    mem_data_out,
  input  logic [WORD_SIZE-1:0]    mem_data_in
);

  localparam logic OWNER_SIM = 1'b1;

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("board_port_arbiter: MEM_LATENCY must be 1..4");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("board_port_arbiter: STARVE_LIMIT must be 1..255");
  end

  logic force_sim_s;
  logic render_gnt_s;
  logic sim_gnt_s;
  logic issue_rd_s;

  logic [LOG_MAX_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic                    mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0]    mem_data_q, mem_data_d;

  // One tag stage per cycle from command issue until the BRAM word is on mem_data_in.
  logic [MEM_LATENCY:0] tag_vld_q, tag_vld_d;
  logic [MEM_LATENCY:0] tag_own_q, tag_own_d;

  logic [WORD_SIZE-1:0] render_data_q, render_data_d;
  logic                 render_valid_q, render_valid_d;
  logic [WORD_SIZE-1:0] sim_data_q, sim_data_d;
  logic                 sim_valid_q, sim_valid_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_LIMIT_C = 8'(STARVE_LIMIT);

  logic [7:0] starve_q, starve_d;

  // Starve counter next state: count denied sim cycles, clear on grant or idle.
  always_comb begin
    starve_d = starve_q;
    if (sim_req_in && !sim_gnt_s) begin
      if (starve_q != 8'hFF) begin
        starve_d = starve_q + 8'd1;
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = 8'd0;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      starve_q <= 8'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign force_sim_s = sim_req_in && (starve_q == STARVE_LIMIT_C);
`else
  assign force_sim_s = 1'b0;
`endif

  // Grants are withheld during reset so no requester believes a transfer happened.
  assign render_gnt_s = rstn_in && render_req_in && !force_sim_s;
  assign sim_gnt_s    = rstn_in && sim_req_in && !render_gnt_s;
  assign issue_rd_s   = render_gnt_s || (sim_gnt_s && !sim_we_in);

  // Memory command next state from the winning requester.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_we_d   = 1'b0;
    mem_data_d = mem_data_q;
    if (render_gnt_s) begin
      mem_addr_d = render_addr_in;
      mem_data_d = {WORD_SIZE{1'b0}};
    end else if (sim_gnt_s) begin
      mem_addr_d = sim_addr_in;
      mem_we_d   = sim_we_in;
      mem_data_d = sim_data_in;
    end else begin
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
    end
  end

  // Owner tag shift register.
  always_comb begin
    tag_vld_d = {tag_vld_q[MEM_LATENCY-1:0], issue_rd_s};
    tag_own_d = {tag_own_q[MEM_LATENCY-1:0], sim_gnt_s};
  end

  // Route the returning BRAM word to its owner; the other side holds its last word.
  always_comb begin
    render_valid_d = 1'b0;
    render_data_d  = render_data_q;
    sim_valid_d    = 1'b0;
    sim_data_d     = sim_data_q;
    if (tag_vld_q[MEM_LATENCY]) begin
      if (tag_own_q[MEM_LATENCY] == OWNER_SIM) begin
        sim_valid_d = 1'b1;
        sim_data_d  = mem_data_in;
      end else begin
        render_valid_d = 1'b1;
        render_data_d  = mem_data_in;
      end
    end else begin
      render_valid_d = 1'b0;
      sim_valid_d    = 1'b0;
    end
  end

  // State registers; reset drops any reads in flight.
  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      mem_addr_q     <= {LOG_MAX_ADDR{1'b0}};
      mem_we_q       <= 1'b0;
      mem_data_q     <= {WORD_SIZE{1'b0}};
      tag_vld_q      <= {(MEM_LATENCY+1){1'b0}};
      tag_own_q      <= {(MEM_LATENCY+1){1'b0}};
      render_data_q  <= {WORD_SIZE{1'b0}};
      render_valid_q <= 1'b0;
      sim_data_q     <= {WORD_SIZE{1'b0}};
      sim_valid_q    <= 1'b0;
    end else begin
      mem_addr_q     <= mem_addr_d;
      mem_we_q       <= mem_we_d;
      mem_data_q     <= mem_data_d;
      tag_vld_q      <= tag_vld_d;
      tag_own_q      <= tag_own_d;
      render_data_q  <= render_data_d;
      render_valid_q <= render_valid_d;
      sim_data_q     <= sim_data_d;
      sim_valid_q    <= sim_valid_d;
    end
  end

  assign render_gnt_out   = render_gnt_s;
  assign sim_gnt_out      = sim_gnt_s;
  assign mem_addr_out     = mem_addr_q;
  assign mem_we_out       = mem_we_q;
  assign mem_data_out     = mem_data_q;
  assign render_data_out  = render_data_q;
  assign render_valid_out = render_valid_q;
  assign sim_data_out     = sim_data_q;
  assign sim_valid_out    = sim_valid_q;

endmodule

// File: tb/tb_board_port_arbiter.sv
// Bench for board_port_arbiter: directed steps plus random traffic against a grant/memory/return model.
// Follows ARB_STARVE_GUARD_EN the same way the design does.
module tb_board_port_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int LAT   = 2;
  localparam int LIMIT = 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          render_req;
  logic [AW-1:0] render_addr;
  logic          render_gnt_out;
  logic [DW-1:0] render_data_out;
  logic          render_valid_out;
  logic          sim_req;
  logic          sim_we;
  logic [AW-1:0] sim_addr;
  logic [DW-1:0] sim_data;
  logic          sim_gnt_out;
  logic [DW-1:0] sim_data_out;
  logic          sim_valid_out;
  logic [AW-1:0] mem_addr_out;
  logic          mem_we_out;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in;

  board_port_arbiter #(
    .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT), .LOG_MAX_ADDR(AW), .WORD_SIZE(DW)
  ) dut (
    .clk_in(clk), .rstn_in(rstn),
    .render_req_in(render_req), .render_addr_in(render_addr), .render_gnt_out(render_gnt_out),
    .render_data_out(render_data_out), .render_valid_out(render_valid_out),
    .sim_req_in(sim_req), .sim_we_in(sim_we), .sim_addr_in(sim_addr), .sim_data_in(sim_data),
    .sim_gnt_out(sim_gnt_out), .sim_data_out(sim_data_out), .sim_valid_out(sim_valid_out),
    .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  // BRAM environment: read-first, LAT cycles from address to data.
  logic [DW-1:0] bram [256];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= bram[mem_addr_out];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (mem_we_out === 1'b1) bram[mem_addr_out] <= mem_data_out;
  end
  assign mem_data_in = rd_pipe[LAT-1];

  // Reference model state.
  typedef struct {
    int          due;
    bit          own;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          pend[$];
  logic [DW-1:0] shadow [256];
  int            scount = 0;
  int            cyc = 0;
  logic [AW-1:0] exp_maddr = '0;
  logic          exp_mwe = 1'b0;
  logic [DW-1:0] exp_mdata = '0;
  logic [DW-1:0] exp_rlast = '0;
  logic [DW-1:0] exp_slast = '0;
  bit            last_eg_r = 1'b0;
  bit            last_eg_s = 1'b0;
  logic          obs_sgnt;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check grants mid-cycle, advance the model, check registered outputs after the edge.
  task automatic cycle();
    bit   force_s, eg_r, eg_s, cmd, chk_data;
    ret_t ent;
    logic exp_rv, exp_sv;
    @(negedge clk);
    force_s = GUARD && sim_req && (scount == LIMIT);
    eg_r = rstn && render_req && !force_s;
    eg_s = rstn && sim_req && !eg_r;
    check("render_gnt", render_gnt_out, eg_r);
    check("sim_gnt", sim_gnt_out, eg_s);
    obs_sgnt  = sim_gnt_out;
    last_eg_r = eg_r;
    last_eg_s = eg_s;
    cmd = 1'b0;
    chk_data = 1'b0;
    if (!rstn) begin
      pend.delete();
      scount = 0;
      exp_maddr = '0; exp_mwe = 1'b0; exp_mdata = '0;
      exp_rlast = '0; exp_slast = '0;
      cmd = 1'b1;
      chk_data = 1'b1;
    end else begin
      exp_mwe = 1'b0;
      if (eg_r) begin
        cmd = 1'b1;
        exp_maddr = render_addr;
        ent.due = cyc + LAT + 2; ent.own = 1'b0; ent.data = shadow[render_addr];
        pend.push_back(ent);
      end else if (eg_s) begin
        cmd = 1'b1;
        exp_maddr = sim_addr;
        exp_mwe = sim_we;
        exp_mdata = sim_data;
        if (sim_we) begin
          shadow[sim_addr] = sim_data;
          chk_data = 1'b1;
        end else begin
          ent.due = cyc + LAT + 2; ent.own = 1'b1; ent.data = shadow[sim_addr];
          pend.push_back(ent);
        end
      end
      if (GUARD) scount = (sim_req && !eg_s) ? ((scount < 255) ? scount + 1 : 255) : 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("mem_we", mem_we_out, exp_mwe);
    if (cmd) check("mem_addr", mem_addr_out, exp_maddr);
    if (chk_data) check("mem_data", mem_data_out, exp_mdata);
    exp_rv = 1'b0;
    exp_sv = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ent = pend.pop_front();
      if (ent.own) begin
        exp_sv = 1'b1; exp_slast = ent.data;
      end else begin
        exp_rv = 1'b1; exp_rlast = ent.data;
      end
    end
    check("render_valid", render_valid_out, exp_rv);
    check("sim_valid", sim_valid_out, exp_sv);
    check("render_data", render_data_out, exp_rlast);
    check("sim_data", sim_data_out, exp_slast);
  endtask

  logic [AW-1:0] addr4 [4];
  int cnt_a, cnt_b;

  initial begin
    for (int i = 0; i < 256; i++) begin
      bram[i]   <= {8'(i) ^ 8'h5A, 8'(i)};
      shadow[i]  = {8'(i) ^ 8'h5A, 8'(i)};
    end
    bram[8'h12]   <= 16'hA5A5;
    shadow[8'h12]  = 16'hA5A5;
    addr4[0] = 8'h05; addr4[1] = 8'h12; addr4[2] = 8'h3C; addr4[3] = 8'h77;

    // Reset held three cycles with both requesters active.
    rstn = 1'b0; render_req = 1'b1; sim_req = 1'b1; sim_we = 1'b1;
    render_addr = 8'h01; sim_addr = 8'h02; sim_data = 16'h1234;
    repeat (3) cycle();
    check("reset_mem_we", mem_we_out, 1'b0);
    check("reset_render_data", render_data_out, 16'h0000);
    rstn = 1'b1; render_req = 1'b0; sim_req = 1'b0; sim_we = 1'b0;
    cnt_a = 0;
    repeat (8) begin
      cycle();
      cnt_a += int'(render_valid_out) + int'(sim_valid_out);
    end
    check("post_reset_valids", cnt_a, 0);

    // Single render read of 0x12.
    render_req = 1'b1; render_addr = 8'h12;
    cycle();
    render_req = 1'b0;
    check("t2_mem_addr", mem_addr_out, 8'h12);
    repeat (3) cycle();
    check("t2_render_valid", render_valid_out, 1'b1);
    check("t2_render_data", render_data_out, 16'hA5A5);
    check("t2_sim_valid", sim_valid_out, 1'b0);

    // Sim write 0x3C <- 0x00FF, then sim read back.
    sim_req = 1'b1; sim_we = 1'b1; sim_addr = 8'h3C; sim_data = 16'h00FF;
    cycle();
    check("t3_mem_we_write", mem_we_out, 1'b1);
    sim_we = 1'b0; sim_data = 16'hDEAD;
    cycle();
    sim_req = 1'b0;
    check("t3_mem_we_read", mem_we_out, 1'b0);
    repeat (3) cycle();
    check("t3_sim_valid", sim_valid_out, 1'b1);
    check("t3_sim_data", sim_data_out, 16'h00FF);

    // Back-to-back alternating reads across four addresses.
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      render_req = (i % 2 == 0); sim_req = (i % 2 == 1); sim_we = 1'b0;
      render_addr = addr4[i % 4]; sim_addr = addr4[(i + 1) % 4];
      cycle();
      cnt_a += int'(render_valid_out); cnt_b += int'(sim_valid_out);
    end
    render_req = 1'b0; sim_req = 1'b0;
    repeat (6) begin
      cycle();
      cnt_a += int'(render_valid_out); cnt_b += int'(sim_valid_out);
    end
    check("t4_render_returns", cnt_a, 4);
    check("t4_sim_returns", cnt_b, 4);

    // Both held high for 100 cycles: starvation guard behaviour.
    cycle();
    render_req = 1'b1; sim_req = 1'b1; sim_we = 1'b0; render_addr = 8'h10; sim_addr = 8'h11;
    cnt_a = 0;
    repeat (100) begin
      cycle();
      cnt_a += int'(obs_sgnt);
    end
    check("t5_sim_grants", cnt_a, GUARD ? 11 : 0);
    render_req = 1'b0; sim_req = 1'b0;
    repeat (6) cycle();

    // Reset two cycles after a render grant drops that read.
    render_req = 1'b1; render_addr = 8'h20;
    cycle();
    render_req = 1'b0;
    cycle();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    cnt_a = 0;
    repeat (8) begin
      cycle();
      cnt_a += int'(render_valid_out);
    end
    check("t6_dropped_read", cnt_a, 0);

    // Random traffic; requesters hold until granted, occasional reset.
    for (int i = 0; i < 400; i++) begin
      if (!(render_req && !last_eg_r)) begin
        render_req  = 1'($urandom_range(0, 1));
        render_addr = 8'($urandom_range(0, 15));
      end
      if (!(sim_req && !last_eg_s)) begin
        sim_req  = 1'($urandom_range(0, 1));
        sim_we   = 1'($urandom_range(0, 1));
        sim_addr = 8'($urandom_range(0, 15));
        sim_data = 16'($urandom);
      end
      rstn = ($urandom_range(0, 63) != 0);
      cycle();
    end
    rstn = 1'b1; render_req = 1'b0; sim_req = 1'b0;
    repeat (8) cycle();
    check("drain_empty", pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
